// File: rtl/customized_sequence_packer.sv
// Write-side producer for the customized-sequence byte FIFO: turns one accepted
// configuration into number, length, cycle and pattern-bit bytes, then waits for drain plus a quiet gap.
module customized_sequence_packer #(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid_i,
    output logic         cfg_ready_o,
    input  logic [7:0]   cfg_number_i,
    input  logic [7:0]   cfg_length_i,
    input  logic [7:0]   cfg_cycle_i,
    input  logic [255:0] cfg_data_i,
    input  logic         wrfifo_full_i,
    input  logic         wrfifo_empty_i,
    output logic         wrfifo_req_o,
    output logic [7:0]   wrfifo_data_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    typedef enum logic [4:0] {
        IDLE       = 5'b00001,
        HDR        = 5'b00010,
        DATA       = 5'b00100,
        WAIT_EMPTY = 5'b01000,
        GAP        = 5'b10000
    } state_e;

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_e         state_q;
    logic [7:0]     number_q;
    logic [7:0]     length_q;
    logic [7:0]     cycle_q;
    logic [255:0]   data_q;
    logic [8:0]     byteIdx_q;
    logic [7:0]     gapCnt_q;
    logic           req_q;
    logic [7:0]     wrData_q;
    logic           done_q;
    logic           err_q;

    logic [7:0]     bitIdx;
    logic [7:0]     curByte;
    logic           cfgIllegal;
    logic           lastByte;

    // Byte index 3+n carries pattern bit n; modulo-256 subtraction keeps indices 256/257 correct.
    always_comb begin
        bitIdx     = byteIdx_q[7:0] - 8'd3;
        cfgIllegal = (cfg_number_i > 8'd3) || (cfg_length_i == 8'd0) || (cfg_cycle_i == 8'd0);
        lastByte   = (byteIdx_q == ({1'b0, length_q} + 9'd2));
        curByte    = 8'd0;
        case (byteIdx_q)
            9'd0:    curByte = number_q;
            9'd1:    curByte = length_q;
            9'd2:    curByte = cycle_q;
            default: curByte = {7'b0, data_q[bitIdx]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            number_q  <= 8'd0;
            length_q  <= 8'd0;
            cycle_q   <= 8'd0;
            data_q    <= '0;
            byteIdx_q <= 9'd0;
            gapCnt_q  <= 8'd0;
            req_q     <= 1'b0;
            wrData_q  <= 8'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_q <= 1'b0;
                    if (cfg_valid_i) begin
                        number_q <= cfg_number_i;
                        length_q <= cfg_length_i;
                        cycle_q  <= cfg_cycle_i;
                        data_q   <= cfg_data_i;
                        if (cfgIllegal) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q   <= HDR;
                            byteIdx_q <= 9'd0;
                        end
                    end
                end
                // A full FIFO stalls the stream in place: no byte is dropped or repeated.
                HDR, DATA: begin
                    if (wrfifo_full_i) begin
                        req_q <= 1'b0;
                    end else begin
                        req_q     <= 1'b1;
                        wrData_q  <= curByte;
                        byteIdx_q <= byteIdx_q + 9'd1;
                        if (state_q == HDR && byteIdx_q == 9'd2) begin
                            state_q <= DATA;
                        end
                        if (state_q == DATA && lastByte) begin
                            done_q  <= 1'b1;
                            state_q <= WAIT_EMPTY;
                        end
                    end
                end
                WAIT_EMPTY: begin
                    req_q <= 1'b0;
                    if (wrfifo_empty_i) begin
                        state_q  <= GAP;
                        gapCnt_q <= 8'd0;
                    end
                end
                GAP: begin
                    req_q <= 1'b0;
                    if (gapCnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gapCnt_q <= gapCnt_q + 8'd1;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign wrfifo_req_o  = req_q;
    assign wrfifo_data_o = wrData_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_customized_sequence_packer.sv
// Bench for customized_sequence_packer: a queue-based model of the byte stream and
// of the drain/gap timing, compared against the DUT every cycle, plus literal pins.
module tb_customized_sequence_packer;

    localparam int GAP = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfgValid = 1'b0;
    logic         cfgReady;
    logic [7:0]   cfgNumber = 8'd0;
    logic [7:0]   cfgLength = 8'd0;
    logic [7:0]   cfgCycle = 8'd0;
    logic [255:0] cfgData = '0;
    logic         wrFull;
    logic         wrEmpty;
    logic         wrReq;
    logic [7:0]   wrData;
    logic         busy;
    logic         done;
    logic         err;

    logic forceFull = 1'b0;
    logic forceEmpty = 1'b1;
    logic randMode = 1'b0;
    logic randFull = 1'b0;
    logic randEmpty = 1'b0;

    int checks = 0;
    int passes = 0;

    customized_sequence_packer #(.GAP_CYCLES(GAP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid_i    (cfgValid),
        .cfg_ready_o    (cfgReady),
        .cfg_number_i   (cfgNumber),
        .cfg_length_i   (cfgLength),
        .cfg_cycle_i    (cfgCycle),
        .cfg_data_i     (cfgData),
        .wrfifo_full_i  (wrFull),
        .wrfifo_empty_i (wrEmpty),
        .wrfifo_req_o   (wrReq),
        .wrfifo_data_o  (wrData),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    assign wrFull  = randMode ? randFull  : forceFull;
    assign wrEmpty = randMode ? randEmpty : forceEmpty;

    always @(negedge clk) begin
        randFull  = ($urandom_range(0, 3) == 0);
        randEmpty = ($urandom_range(0, 2) == 0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Reference model: a queue of bytes still owed to the FIFO, then drain, then a gap countdown.
    int         cycleNum = 0;
    int         acceptCyc = 0;
    logic [7:0] expQ[$];
    logic       expReady = 1'b1;
    logic       expReq = 1'b0;
    logic       expDone = 1'b0;
    logic       expErr = 1'b0;
    logic [7:0] expData = 8'd0;
    logic       drainPending = 1'b0;
    int         gapLeft = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expQ.delete();
            expReady = 1'b1;
            expReq = 1'b0;
            expDone = 1'b0;
            expErr = 1'b0;
            expData = 8'd0;
            drainPending = 1'b0;
            gapLeft = 0;
        end else begin
            cycleNum++;
            expErr = 1'b0;
            expDone = 1'b0;
            if (expQ.size() > 0) begin
                if (!wrFull) begin
                    expReq = 1'b1;
                    expData = expQ.pop_front();
                    if (expQ.size() == 0) begin
                        expDone = 1'b1;
                        drainPending = 1'b1;
                    end
                end else begin
                    expReq = 1'b0;
                end
            end else if (drainPending) begin
                expReq = 1'b0;
                if (wrEmpty) begin
                    drainPending = 1'b0;
                    gapLeft = GAP;
                end
            end else if (gapLeft > 0) begin
                expReq = 1'b0;
                gapLeft--;
            end else begin
                expReq = 1'b0;
                if (cfgValid) begin
                    acceptCyc = cycleNum;
                    if (cfgNumber > 8'd3 || cfgLength == 8'd0 || cfgCycle == 8'd0) begin
                        expErr = 1'b1;
                    end else begin
                        expQ.push_back(cfgNumber);
                        expQ.push_back(cfgLength);
                        expQ.push_back(cfgCycle);
                        for (int i = 0; i < int'(cfgLength); i++) expQ.push_back({7'b0, cfgData[i]});
                    end
                end
            end
            expReady = (expQ.size() == 0) && !drainPending && (gapLeft == 0);
        end
    end

    // Compare and monitor process, away from the active edge.
    logic       prevReady = 1'b1;
    int         doneCyc = 0;
    int         readyCyc = 0;
    int         errCount = 0;
    logic [7:0] logQ[$];

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("cfg_ready", cfgReady, expReady);
            checkOutput("busy", busy, !expReady);
            checkOutput("wrfifo_req", wrReq, expReq);
            checkOutput("done", done, expDone);
            checkOutput("err", err, expErr);
            if (expReq) checkOutput("wrfifo_data", wrData, expData);
            if (wrReq) logQ.push_back(wrData);
            if (done) doneCyc = cycleNum;
            if (err) errCount++;
            if (cfgReady && !prevReady) readyCyc = cycleNum;
        end
        prevReady = cfgReady;
    end

    task automatic waitModelIdle(input int bound);
        int n = 0;
        @(negedge clk);
        while (!expReady && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_wait", expReady, 1);
    endtask

    task automatic applyStimulus(input logic [7:0] num, input logic [7:0] len,
                                 input logic [7:0] cyc, input logic [255:0] data);
        waitModelIdle(3000);
        cfgNumber = num;
        cfgLength = len;
        cfgCycle = cyc;
        cfgData = data;
        cfgValid = 1'b1;
        @(negedge clk);
        cfgValid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int logStart;
        int errStart;
        int readyBefore;
        int emptyCyc;
        logic [255:0] alt;
        logic [7:0] basicBytes [6];
        basicBytes = '{8'h02, 8'h03, 8'h05, 8'h01, 8'h00, 8'h01};

        repeat (2) @(negedge clk);
        checkOutput("reset cfg_ready", cfgReady, 1);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset req", wrReq, 0);
        checkOutput("reset data", wrData, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset err", err, 0);
        rst_n = 1'b1;

        $display("[TB] basic packet");
        logStart = logQ.size();
        applyStimulus(8'd2, 8'd3, 8'd5, 256'b101);
        waitModelIdle(100);
        repeat (2) @(negedge clk);
        checkOutput("basic count", logQ.size() - logStart, 6);
        for (int k = 0; k < 6; k++)
            checkOutput($sformatf("basic byte%0d", k), logQ[logStart + k], basicBytes[k]);
        checkOutput("basic done latency", doneCyc - acceptCyc, 6);
        checkOutput("basic ready latency", readyCyc - doneCyc, 1 + GAP);

        $display("[TB] maximum length");
        alt = '0;
        for (int i = 0; i < 256; i += 2) alt[i] = 1'b1;
        logStart = logQ.size();
        applyStimulus(8'd1, 8'd255, 8'd7, alt);
        waitModelIdle(600);
        repeat (2) @(negedge clk);
        checkOutput("maxlen count", logQ.size() - logStart, 258);
        checkOutput("maxlen 4th byte", logQ[logStart + 3], 8'h01);
        // Bit 254 is even in this pattern, so the final byte is 01.
        checkOutput("maxlen last byte", logQ[logStart + 257], 8'h01);
        checkOutput("maxlen done latency", doneCyc - acceptCyc, 258);

        $display("[TB] backpressure");
        logStart = logQ.size();
        applyStimulus(8'd3, 8'd8, 8'd2, 256'hA5);
        repeat (5) @(negedge clk);
        forceFull = 1'b1;
        repeat (3) @(negedge clk);
        forceFull = 1'b0;
        waitModelIdle(100);
        checkOutput("bp count", logQ.size() - logStart, 11);
        checkOutput("bp done latency", doneCyc - acceptCyc, 14);

        $display("[TB] illegal configurations");
        errStart = errCount;
        logStart = logQ.size();
        applyStimulus(8'd4, 8'd3, 8'd3, 256'h7);
        applyStimulus(8'd1, 8'd0, 8'd3, 256'h7);
        applyStimulus(8'd1, 8'd3, 8'd0, 256'h7);
        repeat (2) @(negedge clk);
        checkOutput("illegal err pulses", errCount - errStart, 3);
        checkOutput("illegal writes", logQ.size() - logStart, 0);

        $display("[TB] drain and gap");
        forceEmpty = 1'b0;
        applyStimulus(8'd0, 8'd4, 8'd1, 256'hF);
        repeat (8) @(negedge clk);
        readyBefore = readyCyc;
        logStart = logQ.size();
        repeat (20) @(negedge clk);
        checkOutput("drain ready held", readyCyc, readyBefore);
        checkOutput("drain writes", logQ.size() - logStart, 0);
        emptyCyc = cycleNum;
        forceEmpty = 1'b1;
        waitModelIdle(50);
        repeat (2) @(negedge clk);
        checkOutput("drain gap latency", readyCyc - emptyCyc, GAP + 1);

        $display("[TB] reset mid-DATA");
        applyStimulus(8'd2, 8'd20, 8'd3, {8{$urandom()}});
        repeat (8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset req", wrReq, 0);
        checkOutput("async reset ready", cfgReady, 1);
        checkOutput("async reset busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        logStart = logQ.size();
        applyStimulus(8'd1, 8'd10, 8'd4, 256'h3C5);
        waitModelIdle(100);
        checkOutput("post-reset count", logQ.size() - logStart, 13);
        checkOutput("post-reset first byte", logQ[logStart], 8'h01);
        checkOutput("post-reset 4th byte", logQ[logStart + 3], 8'h01);

        $display("[TB] randomized packets");
        randMode = 1'b1;
        for (int p = 0; p < 30; p++) begin
            applyStimulus(8'($urandom_range(0, 4)), 8'($urandom_range(0, 60)),
                          8'($urandom_range(0, 255)), {8{$urandom()}});
        end
        waitModelIdle(3000);
        randMode = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
